mdu_seq: RTL and testbench

MDU_SEQ -- requirements
Module: mdu_seq

---
 rtl/mdu_if.sv | 25 ++
 rtl/mdu_seq.sv | 160 ++++++++++++++++
 tb/tb_mdu_seq.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_if.sv
// Request/response bundle between the issue stage and the sequential multiply/divide unit.
interface mdu_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [1:0]      ALUOP;
  logic            instr_25;
  logic [2:0]      func3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            kill;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, ALUOP, instr_25, func3, rs1, rs2, kill,
    input  busy, done, result
  );

  modport slave (
    input  start, ALUOP, instr_25, func3, rs1, rs2, kill,
    output busy, done, result
  );
endinterface

// File: rtl/mdu_seq.sv
// Sequential RV32M-style multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle on magnitudes, sign fixed up at the end.
module mdu_seq #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic clk,
  input  logic rst_n,
  mdu_if.slave bus
);

  localparam int unsigned      PW        = 2 * XLEN;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  acc_hi_q, acc_hi_d;
  logic [XLEN-1:0]  acc_lo_q, acc_lo_d;
  logic [XLEN-1:0]  op_b_q, op_b_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [2:0]       func3_q, func3_d;
  logic             neg_q, neg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, done_q;

  logic             accept_c, is_div_c, a_signed_c, b_signed_c;
  logic             a_neg_c, b_neg_c, div_zero_c, div_ovf_c, neg_req_c;
  logic [XLEN-1:0]  abs_a_c, abs_b_c, special_c;

  // Request decode on the raw operands
  assign accept_c   = bus.start && (bus.ALUOP == 2'b10) && bus.instr_25 && !bus.kill;
  assign is_div_c   = bus.func3[2];
  assign a_signed_c = (bus.func3 == 3'b001) || (bus.func3 == 3'b010) ||
                      (bus.func3 == 3'b100) || (bus.func3 == 3'b110);
  assign b_signed_c = (bus.func3 == 3'b001) || (bus.func3 == 3'b100) || (bus.func3 == 3'b110);
  assign a_neg_c    = a_signed_c && bus.rs1[XLEN-1];
  assign b_neg_c    = b_signed_c && bus.rs2[XLEN-1];
  assign abs_a_c    = a_neg_c ? (~bus.rs1 + XLEN'(1)) : bus.rs1;
  assign abs_b_c    = b_neg_c ? (~bus.rs2 + XLEN'(1)) : bus.rs2;
  assign div_zero_c = is_div_c && (bus.rs2 == '0);
  assign div_ovf_c  = is_div_c && b_signed_c && (bus.rs1 == INT_MIN) && (bus.rs2 == '1);
  // Remainder takes the dividend's sign; quotient and product take the xor
  assign neg_req_c  = (bus.func3 == 3'b110) ? a_neg_c : (a_neg_c ^ b_neg_c);
  assign special_c  = div_zero_c ? (bus.func3[1] ? bus.rs1 : '1)
                                 : (bus.func3[1] ? '0 : bus.rs1);

  logic [XLEN:0]   mul_sum_c, div_trial_c, div_diff_c;
  logic [PW-1:0]   prod_c;
  logic [XLEN-1:0] quo_c, rem_c, fix_c;

  // Per-cycle iteration datapath
  assign mul_sum_c   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, op_b_q} : '0);
  assign div_trial_c = {acc_hi_q, acc_lo_q[XLEN-1]};
  assign div_diff_c  = div_trial_c - {1'b0, op_b_q};

  // Sign correction applied in FIX
  assign prod_c = neg_q ? (~{acc_hi_q, acc_lo_q} + PW'(1)) : {acc_hi_q, acc_lo_q};
  assign quo_c  = neg_q ? (~acc_lo_q + XLEN'(1)) : acc_lo_q;
  assign rem_c  = neg_q ? (~acc_hi_q + XLEN'(1)) : acc_hi_q;

  always_comb begin
    fix_c = prod_c[PW-1:XLEN];
    case (func3_q)
      3'b000:         fix_c = prod_c[XLEN-1:0];
      3'b100, 3'b101: fix_c = quo_c;
      3'b110, 3'b111: fix_c = rem_c;
      default:        fix_c = prod_c[PW-1:XLEN];
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    op_b_d   = op_b_q;
    result_d = result_q;
    func3_d  = func3_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;

    if (bus.kill) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            func3_d  = bus.func3;
            neg_d    = neg_req_c;
            cnt_d    = '0;
            acc_hi_d = '0;
            acc_lo_d = is_div_c ? abs_a_c : abs_b_c;
            op_b_d   = is_div_c ? abs_b_c : abs_a_c;
            if (div_zero_c || div_ovf_c) begin
              result_d = special_c;
              state_d  = DONE;
            end else begin
              state_d  = CALC;
            end
          end
        end
        CALC: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (func3_q[2]) begin
            if (!div_diff_c[XLEN]) begin
              acc_hi_d = div_diff_c[XLEN-1:0];
              acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b1};
            end else begin
              acc_hi_d = div_trial_c[XLEN-1:0];
              acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b0};
            end
          end else begin
            acc_hi_d = mul_sum_c[XLEN:1];
            acc_lo_d = {mul_sum_c[0], acc_lo_q[XLEN-1:1]};
          end
          if (cnt_q == LAST_STEP) state_d = FIX;
        end
        FIX: begin
          result_d = fix_c;
          state_d  = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      func3_q  <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      func3_q  <= func3_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == DONE);
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: cycle-level reference model compared every cycle,
// plus hand-computed result and latency pins for each directed operation.
module tb_mdu_seq;

  localparam int unsigned XLEN     = 32;
  localparam int          NORM_LAT = XLEN + 2;

  logic clk = 1'b0;
  logic rst_n;

  mdu_if #(.XLEN(XLEN)) bus ();

  mdu_seq #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Architectural result from plain wide arithmetic
  function automatic logic [XLEN-1:0] ref_result(input logic [2:0] f,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    logic signed [2*XLEN-1:0] sa, sb, sp;
    logic [2*XLEN-1:0]        up;
    logic signed [XLEN-1:0]   da, db;
    logic                     is_ovf;
    sa = {{XLEN{a[XLEN-1]}}, a};
    sb = {{XLEN{b[XLEN-1]}}, b};
    up = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
    da = a;
    db = b;
    is_ovf = (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    case (f)
      3'd0: return up[XLEN-1:0];
      3'd1: begin sp = sa * sb; return sp[2*XLEN-1:XLEN]; end
      3'd2: begin sb = {{XLEN{1'b0}}, b}; sp = sa * sb; return sp[2*XLEN-1:XLEN]; end
      3'd3: return up[2*XLEN-1:XLEN];
      3'd4: begin
        if (b == '0) return '1;
        if (is_ovf) return a;
        return XLEN'(da / db);
      end
      3'd5: begin
        if (b == '0) return '1;
        return a / b;
      end
      3'd6: begin
        if (b == '0) return a;
        if (is_ovf) return '0;
        return XLEN'(da % db);
      end
      default: begin
        if (b == '0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Edges after the accept edge until done: early-out cases finish on the accept edge
  function automatic int ref_edges(input logic [2:0] f, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b);
    logic early;
    early = (f[2] && (b == '0)) ||
            (((f == 3'd4) || (f == 3'd6)) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1));
    return early ? 0 : XLEN + 1;
  endfunction

  logic            m_busy = 1'b0;
  logic            m_done = 1'b0;
  logic [XLEN-1:0] m_result = '0;
  logic [XLEN-1:0] m_pending = '0;
  int              m_left = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy    <= 1'b0;
      m_done    <= 1'b0;
      m_result  <= '0;
      m_pending <= '0;
      m_left    <= 0;
    end else if (bus.kill) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end else if (m_busy) begin
      if (m_done) begin
        m_busy <= 1'b0;
        m_done <= 1'b0;
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done   <= 1'b1;
          m_result <= m_pending;
        end
      end
    end else if (bus.start && (bus.ALUOP == 2'b10) && bus.instr_25) begin
      m_busy    <= 1'b1;
      m_pending <= ref_result(bus.func3, bus.rs1, bus.rs2);
      m_left    <= ref_edges(bus.func3, bus.rs1, bus.rs2);
      if (ref_edges(bus.func3, bus.rs1, bus.rs2) == 0) begin
        m_done   <= 1'b1;
        m_result <= ref_result(bus.func3, bus.rs1, bus.rs2);
      end
    end
  end

  int              n_chk = 0;
  int              n_pass = 0;
  string           lit_name = "";
  logic [XLEN-1:0] lit_res = '0;
  int              lit_lat = 0;
  int              lit_seq = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
  endtask

  // Single compare process
  initial begin
    int lat_cnt;
    int seen_seq;
    lat_cnt  = 0;
    seen_seq = 0;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        #1;
        chk("reset_busy",   64'(bus.busy),   64'd0);
        chk("reset_done",   64'(bus.done),   64'd0);
        chk("reset_result", 64'(bus.result), 64'd0);
        lat_cnt = 0;
      end else begin
        lat_cnt = bus.busy ? lat_cnt + 1 : 0;
        chk("busy",   64'(bus.busy),   64'(m_busy));
        chk("done",   64'(bus.done),   64'(m_done));
        chk("result", 64'(bus.result), 64'(m_result));
        if (bus.done && (lit_seq != seen_seq)) begin
          seen_seq = lit_seq;
          chk({lit_name, "_result"},  64'(bus.result), 64'(lit_res));
          chk({lit_name, "_latency"}, 64'(lat_cnt),    64'(lit_lat));
        end
      end
    end
  end

  task automatic arm(input string nm, input logic [XLEN-1:0] r, input int l);
    lit_name = nm;
    lit_res  = r;
    lit_lat  = l;
    lit_seq  = lit_seq + 1;
  endtask

  task automatic drive_req(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    bus.start    = 1'b1;
    bus.ALUOP    = 2'b10;
    bus.instr_25 = 1'b1;
    bus.func3    = f;
    bus.rs1      = a;
    bus.rs2      = b;
  endtask

  // Operands wander after acceptance; the latched copy must be used
  task automatic scramble();
    bus.start    = 1'b0;
    bus.ALUOP    = 2'($urandom);
    bus.instr_25 = 1'($urandom);
    bus.func3    = 3'($urandom);
    bus.rs1      = $urandom;
    bus.rs2      = $urandom;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (n < 80) begin
      @(negedge clk);
      if (bus.done) break;
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string nm, input logic [2:0] f, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] r, input int l);
    arm(nm, r, l);
    drive_req(f, a, b);
    @(posedge clk);
    #1;
    scramble();
    wait_done();
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.ALUOP    = 2'b00;
    bus.instr_25 = 1'b0;
    bus.func3    = 3'b000;
    bus.rs1      = '0;
    bus.rs2      = '0;
    bus.kill     = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    run_op("mul_7_m3",      3'b000, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, NORM_LAT);
    run_op("mulhu_ones",    3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, NORM_LAT);
    run_op("mulh_ones",     3'b001, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, NORM_LAT);
    run_op("mulhsu_m1_2",   3'b010, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF, NORM_LAT);
    run_op("mulh_min_min",  3'b001, 32'h80000000,   32'h80000000, 32'h40000000, NORM_LAT);
    run_op("mulhsu_min",    3'b010, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, NORM_LAT);
    run_op("div_m7_2",      3'b100, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, NORM_LAT);
    run_op("rem_m7_2",      3'b110, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, NORM_LAT);
    run_op("divu_100_7",    3'b101, 32'd100,        32'd7,        32'd14,       NORM_LAT);
    run_op("remu_100_7",    3'b111, 32'd100,        32'd7,        32'd2,        NORM_LAT);
    run_op("div_7_m2",      3'b100, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, NORM_LAT);
    run_op("rem_7_m2",      3'b110, 32'd7,          32'hFFFFFFFE, 32'd1,        NORM_LAT);
    run_op("div_min_2",     3'b100, 32'h80000000,   32'd2,        32'hC0000000, NORM_LAT);
    run_op("divu_big",      3'b101, 32'hFFFFFFFF,   32'h10,       32'h0FFFFFFF, NORM_LAT);
    run_op("remu_big",      3'b111, 32'hFFFFFFFF,   32'h10,       32'h0000000F, NORM_LAT);
    run_op("divu_by0",      3'b101, 32'd5,          32'd0,        32'hFFFFFFFF, 1);
    run_op("remu_by0",      3'b111, 32'd5,          32'd0,        32'd5,        1);
    run_op("div_m5_by0",    3'b100, 32'hFFFFFFFB,   32'd0,        32'hFFFFFFFF, 1);
    run_op("rem_m5_by0",    3'b110, 32'hFFFFFFFB,   32'd0,        32'hFFFFFFFB, 1);
    run_op("div_ovf",       3'b100, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf",       3'b110, 32'h80000000,   32'hFFFFFFFF, 32'd0,        1);

    // Kill during CALC, with a competing start in the same cycle
    drive_req(3'b000, 32'd3, 32'd4);
    @(posedge clk);
    #1;
    scramble();
    repeat (9) @(posedge clk);
    #1;
    bus.kill = 1'b1;
    drive_req(3'b011, 32'd9, 32'd9);
    @(posedge clk);
    #1;
    bus.kill = 1'b0;
    scramble();
    repeat (40) @(posedge clk);
    #1;

    // Kill and start together while idle
    bus.kill = 1'b1;
    drive_req(3'b000, 32'd5, 32'd5);
    @(posedge clk);
    #1;
    bus.kill = 1'b0;
    scramble();
    repeat (3) @(posedge clk);
    #1;

    // Starts that must be ignored: not an M op, not R-type
    drive_req(3'b000, 32'd2, 32'd3);
    bus.instr_25 = 1'b0;
    @(posedge clk);
    #1;
    scramble();
    drive_req(3'b000, 32'd2, 32'd3);
    bus.ALUOP = 2'b00;
    @(posedge clk);
    #1;
    scramble();
    repeat (2) @(posedge clk);
    #1;

    // Start while busy is ignored
    arm("divu_busy", 32'd14, NORM_LAT);
    drive_req(3'b101, 32'd100, 32'd7);
    @(posedge clk);
    #1;
    scramble();
    repeat (4) @(posedge clk);
    #1;
    drive_req(3'b000, 32'd2, 32'd3);
    @(posedge clk);
    #1;
    scramble();
    wait_done();

    // Asynchronous reset between edges in the middle of a divide
    drive_req(3'b100, 32'd1000, 32'd3);
    @(posedge clk);
    #1;
    scramble();
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    run_op("mulhu_after_rst", 3'b011, 32'h12345678, 32'h10, 32'h1, NORM_LAT);
    run_op("mul_after_rst",   3'b000, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, NORM_LAT);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
